// File: rtl/pe_result_collector.sv
// Result sink for the last PE: reservation-based ready, FWFT buffer, job counting.
// Optional sticky Overflow flag is built when COLLECTOR_OVERFLOW_CHECK_EN is defined.
module pe_result_collector #(
    parameter int DataWidth       = 32,
    parameter int Pipeline_Stages = 12,
    parameter int BufferWidth     = 4,
    parameter int BufferSize      = 16,
    parameter int CountWidth      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DataWidth-1:0]  O_DataIn,
    input  logic                  O_DataInValid,
    output logic                  O_DataInRdy,
    output logic [DataWidth-1:0]  Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Rdy,
    input  logic [CountWidth-1:0] Expected,
    input  logic                  Start,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int InflightWidth = $clog2(Pipeline_Stages + 1);

    state_e                     state_q, state_d;
    logic [BufferWidth:0]       occ_q, occ_d;
    logic [InflightWidth-1:0]   inflight_q, inflight_d;
    logic [Pipeline_Stages-1:0] res_q, res_d;
    logic [CountWidth-1:0]      received_q, received_d;
    logic [CountWidth-1:0]      expected_q, expected_d;
    logic [BufferWidth-1:0]     wr_ptr_q, wr_ptr_d;
    logic [BufferWidth-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0]       mem_q [BufferSize];

    logic start_ok, push, pop, full, accept_state, ready;

    // Ready depends only on registered state so the last PE sees no input-to-output path.
    always_comb begin
        ready        = (state_q == COLLECT) && (received_q < expected_q) &&
                       ((32'(occ_q) + 32'(inflight_q)) < 32'(BufferSize));
        start_ok     = (state_q == IDLE) && Start;
        pop          = (occ_q != '0) && Out_Rdy;
        full         = (occ_q == (BufferWidth+1)'(BufferSize));
        accept_state = (state_q == COLLECT) || (state_q == DRAIN);
        push         = O_DataInValid && accept_state && (!full || pop);
    end

    always_comb begin
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        received_d = received_q;
        expected_d = expected_q;
        inflight_d = inflight_q;
        res_d      = {res_q[Pipeline_Stages-2:0], ready};

        if (push && !pop) occ_d = occ_q + (BufferWidth+1)'(1);
        else if (pop && !push) occ_d = occ_q - (BufferWidth+1)'(1);
        if (push) wr_ptr_d = wr_ptr_q + BufferWidth'(1);
        if (pop) rd_ptr_d = rd_ptr_q + BufferWidth'(1);

        if (start_ok) begin
            received_d = '0;
            expected_d = Expected;
        end else if (push) begin
            received_d = received_q + CountWidth'(1);
        end

        // A grant retires Pipeline_Stages cycles after it was issued.
        case ({ready, res_q[Pipeline_Stages-1]})
            2'b10:   inflight_d = inflight_q + InflightWidth'(1);
            2'b01:   inflight_d = inflight_q - InflightWidth'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = (Expected != '0) ? COLLECT : DONE;
            COLLECT: if (received_q >= expected_q) state_d = DRAIN;
            DRAIN:   if ((inflight_q == '0) && (occ_q == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            inflight_q <= '0;
            res_q      <= '0;
            received_q <= '0;
            expected_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            res_q      <= res_d;
            received_q <= received_d;
            expected_q <= expected_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= O_DataIn;
    end

`ifdef COLLECTOR_OVERFLOW_CHECK_EN
    logic overflow_q;
    logic illegal;

    assign illegal = O_DataInValid && !push;

    always_ff @(posedge clk) begin
        if (!rst) overflow_q <= 1'b0;
        else if (start_ok) overflow_q <= 1'b0;
        else if (illegal) overflow_q <= 1'b1;
    end

    assign Overflow = overflow_q;
`else
    assign Overflow = 1'b0;
`endif

    assign O_DataInRdy = ready;
    assign Out_Valid   = (occ_q != '0);
    assign Out_Data    = Out_Valid ? mem_q[rd_ptr_q] : '0;
    assign Busy        = (state_q == COLLECT) || (state_q == DRAIN);
    assign Done        = (state_q == DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector with a 12-cycle PE model and an in-order scoreboard.
module tb_pe_result_collector;
    localparam int DW = 32;
    localparam int CW = 16;

`ifdef COLLECTOR_OVERFLOW_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] o_data_in;
    logic          o_data_in_valid;
    logic          o_data_in_rdy;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_rdy;
    logic [CW-1:0] expected;
    logic          start;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    pe_result_collector dut (
        .clk          (clk),
        .rst          (rst),
        .O_DataIn     (o_data_in),
        .O_DataInValid(o_data_in_valid),
        .O_DataInRdy  (o_data_in_rdy),
        .Out_Data     (out_data),
        .Out_Valid    (out_valid),
        .Out_Rdy      (out_rdy),
        .Expected     (expected),
        .Start        (start),
        .Busy         (busy),
        .Done         (done),
        .Overflow     (overflow),
        .dbg_state_o  (dbg_state)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    logic [DW-1:0] exp_q[$];
    logic          sched_v [256];
    logic [DW-1:0] sched_d [256];
    logic pe_vin, force_vin;
    int pe_budget, pe_issued, pe_gap_at, pe_hold_until, pe_base;
    int pending, held, popped, arrivals, job_exp, last_arr_cyc, last_arr_state;
    int grants, done_cnt, done_cyc, rdy_late, max_out, s;
    logic busy_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic new_job(input int exp_n, input int budget, input int gap_at, input int base);
        job_exp = exp_n; pe_budget = budget; pe_gap_at = gap_at; pe_base = base;
        pe_issued = 0; pe_hold_until = 0; pending = 0; held = 0; popped = 0;
        arrivals = 0; last_arr_cyc = -1; last_arr_state = 0; grants = 0;
        done_cnt = 0; done_cyc = 0; rdy_late = 0; max_out = 0;
        exp_q.delete();
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 256; i++) begin
            sched_v[i] = 1'b0;
            sched_d[i] = '0;
        end
    endtask

    // One clock: account for what happened at the edge, run the PE model, drive next inputs.
    task automatic step();
        logic rdy_pre, pop_pre, pe_vin_pre;
        logic [DW-1:0] data_pre, d;
        logic [1:0] st_pre;
        int slot;
        rdy_pre = o_data_in_rdy; pop_pre = out_valid && out_rdy;
        data_pre = out_data; pe_vin_pre = pe_vin; st_pre = dbg_state;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_pre === 1'b1) begin
            popped++; held--;
            if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
            else check("pop_data", data_pre, exp_q.pop_front());
        end
        if (pe_vin_pre === 1'b1) begin
            arrivals++; pending--; held++;
            last_arr_state = int'(st_pre);
            if (arrivals == job_exp) last_arr_cyc = cyc - 1;
            if (arrivals == 1) begin
                check("lat_out_valid", out_valid, 1);
                check("lat_out_data", out_data, exp_q[0]);
            end
        end
        if (rdy_pre === 1'b1) begin
            grants++;
            if (pe_issued < pe_budget && (cyc - 1) >= pe_hold_until) begin
                d = DW'(pe_base + pe_issued);
                slot = (cyc + 11) % 256;
                sched_v[slot] = 1'b1; sched_d[slot] = d;
                exp_q.push_back(d);
                pe_issued++; pending++;
                if (pe_issued == pe_gap_at) pe_hold_until = cyc - 1 + 3;
            end
        end
        slot = cyc % 256;
        pe_vin = sched_v[slot];
        o_data_in = sched_v[slot] ? sched_d[slot] : (force_vin ? 32'hDEAD_BEEF : '0);
        o_data_in_valid = sched_v[slot] | force_vin;
        sched_v[slot] = 1'b0;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (last_arr_cyc >= 0 && cyc > last_arr_cyc && o_data_in_rdy === 1'b1) rdy_late++;
        if (pending + held > max_out) max_out = pending + held;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            busy_prev = busy;
            step();
        end
        if (done_cnt == 0) check(tag, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_sched();
        new_job(0, 0, 0, 0);
        rst = 1'b0; start = 1'b1; force_vin = 1'b1; pe_vin = 1'b0;
        o_data_in_valid = 1'b1; o_data_in = 32'hDEAD_BEEF; expected = 16'd8; out_rdy = 1'b0;

        // Reset held for two edges with valid and Start asserted.
        step(); step();
        force_vin = 1'b0; o_data_in_valid = 1'b0; start = 1'b0; rst = 1'b1;
        step();
        check("rst_rdy", o_data_in_rdy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", dbg_state, 0);

        // Streaming: 8 results, host always ready.
        new_job(8, 8, 0, 32'hA000_0000);
        out_rdy = 1'b1; expected = 16'd8; start = 1'b1; s = cyc;
        step(); start = 1'b0;
        run_to_done("stream_timeout", 200);
        check("stream_busy_at_done", busy, 0);
        check("stream_busy_before_done", busy_prev, 1);
        check("stream_done_cyc", done_cyc - s, 34);
        repeat (4) step();
        check("stream_done_once", done_cnt, 1);
        check("stream_words", popped, 8);
        check("stream_q_empty", exp_q.size(), 0);
        check("stream_grants", grants, 20);
        check("stream_rdy_after_last", rdy_late, 0);
        check("stream_overflow", overflow, 0);

        // Back-pressure: 40 results, host stalled, then released.
        new_job(40, 40, 0, 32'hB000_0000);
        out_rdy = 1'b0; expected = 16'd40; start = 1'b1;
        step(); start = 1'b0;
        repeat (60) step();
        check("bp_held", held, 16);
        check("bp_rdy_low", o_data_in_rdy, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_busy", busy, 1);
        out_rdy = 1'b1;
        run_to_done("bp_timeout", 400);
        repeat (3) step();
        check("bp_words", popped, 40);
        check("bp_q_empty", exp_q.size(), 0);
        check("bp_done_once", done_cnt, 1);
        check("bp_outstanding_le16", max_out <= 16, 1);
        check("bp_overflow", overflow, 0);

        // Late legally reserved result arrives in DRAIN.
        new_job(3, 4, 3, 32'hC000_0000);
        out_rdy = 1'b1; expected = 16'd3; start = 1'b1; s = cyc;
        step(); start = 1'b0;
        run_to_done("late_timeout", 200);
        check("late_done_cyc", done_cyc - s, 29);
        repeat (3) step();
        check("late_words", popped, 4);
        check("late_q_empty", exp_q.size(), 0);
        check("late_in_drain", last_arr_state, 2);
        check("late_done_once", done_cnt, 1);
        check("late_rdy_after_last", rdy_late, 0);

        // Illegal arrival in IDLE, then a zero-length job.
        new_job(0, 0, 0, 0);
        o_data_in_valid = 1'b1; o_data_in = 32'hDEAD_BEEF;
        step();
        check("ovf_set", overflow, OVF_EXP);
        check("ovf_dropped", out_valid, 0);
        repeat (3) step();
        check("ovf_sticky", overflow, OVF_EXP);
        expected = 16'd0; start = 1'b1; s = cyc;
        step(); start = 1'b0;
        check("zl_done", done, 1);
        check("zl_ovf_cleared", overflow, 0);
        check("zl_busy", busy, 0);
        step();
        check("zl_done_pulse", done, 0);
        check("zl_state_idle", dbg_state, 0);
        check("zl_no_grant", grants, 0);

        // Reset in the middle of a stalled job discards buffered words.
        new_job(5, 5, 0, 32'hD000_0000);
        out_rdy = 1'b0; expected = 16'd5; start = 1'b1;
        step(); start = 1'b0;
        repeat (20) step();
        check("mid_buffered", out_valid, 1);
        clear_sched(); pe_budget = 0; rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_rdy", o_data_in_rdy, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", dbg_state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
